// File: rtl/pwm_duty_sequencer.sv
// Single writer of the 8-bit PWM duty word: MANUAL stepping from debounced buttons or an autonomous
// BREATHE fade. Optional macro GAMMA_CORRECT_EN adds a registered ((d*d)+255)>>8 output map.
`timescale 1ns/1ps

module pwm_duty_sequencer #(
   parameter int TICK_DIV       = 262144,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int HOLD_TICKS     = 64,
   parameter int STEP           = 1
) (
   input  logic       CLK_i,
   input  logic       RST_i,
   input  logic       BTN_UP_N_i,
   input  logic       BTN_DN_N_i,
   input  logic       MODE_i,
   output logic [7:0] duty_o,
   output logic       tick_o,
   output logic [2:0] state_o
);

   localparam int TCW = $clog2(TICK_DIV);
   localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HW  = $clog2(HOLD_TICKS + 1);

   typedef enum logic [2:0] {
      ST_MANUAL    = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_HOLD_TOP  = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_HOLD_BOT  = 3'd4
   } state_t;

   // One tick-qualified debounce step; returns {next level, next run count}.
   function automatic logic [DBW:0] deb_step(input logic level, input logic sample,
                                             input logic [DBW-1:0] run, input logic tick);
      logic           lvl;
      logic [DBW-1:0] cnt;
      lvl = level;
      cnt = run;
      if (!tick) begin
         cnt = run;
      end else if (sample == level) begin
         cnt = {DBW{1'b0}};
      end else if (run == DBW'(DEBOUNCE_TICKS - 1)) begin
         lvl = sample;
         cnt = {DBW{1'b0}};
      end else begin
         cnt = run + DBW'(1);
      end
      return {lvl, cnt};
   endfunction

   logic           up_meta_r, up_sync_r, dn_meta_r, dn_sync_r, mode_meta_r, mode_sync_r;
   logic [TCW-1:0] cnt_r, cnt_nxt_s;
   logic           tick_r;
   logic           up_deb_r, dn_deb_r, up_deb_nxt_s, dn_deb_nxt_s;
   logic [DBW-1:0] up_run_r, dn_run_r, up_run_nxt_s, dn_run_nxt_s;
   logic           up_press_s, dn_press_s;
   logic [8:0]     up_sum_s, dn_diff_s;
   logic [7:0]     duty_up_s, duty_dn_s;
   state_t         state_r, state_nxt_s;
   logic [7:0]     duty_r, duty_nxt_s;
   logic [HW-1:0]  hold_r, hold_nxt_s;

   // Two-flop synchronisers for the asynchronous buttons and mode switch.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         up_meta_r   <= 1'b1;
         up_sync_r   <= 1'b1;
         dn_meta_r   <= 1'b1;
         dn_sync_r   <= 1'b1;
         mode_meta_r <= 1'b0;
         mode_sync_r <= 1'b0;
      end else begin
         up_meta_r   <= BTN_UP_N_i;
         up_sync_r   <= up_meta_r;
         dn_meta_r   <= BTN_DN_N_i;
         dn_sync_r   <= dn_meta_r;
         mode_meta_r <= MODE_i;
         mode_sync_r <= mode_meta_r;
      end
   end

   // Tick divider next count.
   always_comb begin
      if (cnt_r == TCW'(TICK_DIV - 1)) begin
         cnt_nxt_s = {TCW{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + TCW'(1);
      end
   end

   // Tick divider; the strobe is registered so it is high exactly while the count sits at its top.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         cnt_r  <= {TCW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == TCW'(TICK_DIV - 1));
      end
   end

   // Debounce next state; the step logic uses the accepted level so a press steps on its accepting tick.
   always_comb begin
      {up_deb_nxt_s, up_run_nxt_s} = deb_step(up_deb_r, up_sync_r, up_run_r, tick_r);
      {dn_deb_nxt_s, dn_run_nxt_s} = deb_step(dn_deb_r, dn_sync_r, dn_run_r, tick_r);
      up_press_s = ~up_deb_nxt_s;
      dn_press_s = ~dn_deb_nxt_s;
   end

   // Debounced button levels and run counters.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         up_deb_r <= 1'b1;
         dn_deb_r <= 1'b1;
         up_run_r <= {DBW{1'b0}};
         dn_run_r <= {DBW{1'b0}};
      end else begin
         up_deb_r <= up_deb_nxt_s;
         dn_deb_r <= dn_deb_nxt_s;
         up_run_r <= up_run_nxt_s;
         dn_run_r <= dn_run_nxt_s;
      end
   end

   // Saturating 9-bit step arithmetic; bit 8 flags overflow on the sum and borrow on the difference.
   always_comb begin
      up_sum_s  = {1'b0, duty_r} + 9'(STEP);
      dn_diff_s = {1'b0, duty_r} - 9'(STEP);
      if (up_sum_s[8]) begin
         duty_up_s = 8'd255;
      end else begin
         duty_up_s = up_sum_s[7:0];
      end
      if (dn_diff_s[8]) begin
         duty_dn_s = 8'd0;
      end else begin
         duty_dn_s = dn_diff_s[7:0];
      end
   end

   // Mode/fade FSM next state; a mode change takes priority over any tick in the same cycle.
   always_comb begin
      state_nxt_s = state_r;
      duty_nxt_s  = duty_r;
      hold_nxt_s  = hold_r;
      case (state_r)
         ST_MANUAL: begin
            if (mode_sync_r) begin
               state_nxt_s = ST_RAMP_UP;
            end else if (tick_r && up_press_s && !dn_press_s) begin
               duty_nxt_s = duty_up_s;
            end else if (tick_r && dn_press_s && !up_press_s) begin
               duty_nxt_s = duty_dn_s;
            end else begin
               duty_nxt_s = duty_r;
            end
         end
         ST_RAMP_UP: begin
            if (!mode_sync_r) begin
               state_nxt_s = ST_MANUAL;
            end else if (tick_r) begin
               duty_nxt_s = duty_up_s;
               if (duty_up_s == 8'd255) begin
                  state_nxt_s = ST_HOLD_TOP;
                  hold_nxt_s  = {HW{1'b0}};
               end else begin
                  state_nxt_s = ST_RAMP_UP;
               end
            end else begin
               duty_nxt_s = duty_r;
            end
         end
         ST_HOLD_TOP: begin
            if (!mode_sync_r) begin
               state_nxt_s = ST_MANUAL;
            end else if (tick_r && (hold_r == HW'(HOLD_TICKS - 1))) begin
               state_nxt_s = ST_RAMP_DOWN;
               hold_nxt_s  = {HW{1'b0}};
            end else if (tick_r) begin
               hold_nxt_s = hold_r + HW'(1);
            end else begin
               hold_nxt_s = hold_r;
            end
         end
         ST_RAMP_DOWN: begin
            if (!mode_sync_r) begin
               state_nxt_s = ST_MANUAL;
            end else if (tick_r) begin
               duty_nxt_s = duty_dn_s;
               if (duty_dn_s == 8'd0) begin
                  state_nxt_s = ST_HOLD_BOT;
                  hold_nxt_s  = {HW{1'b0}};
               end else begin
                  state_nxt_s = ST_RAMP_DOWN;
               end
            end else begin
               duty_nxt_s = duty_r;
            end
         end
         ST_HOLD_BOT: begin
            if (!mode_sync_r) begin
               state_nxt_s = ST_MANUAL;
            end else if (tick_r && (hold_r == HW'(HOLD_TICKS - 1))) begin
               state_nxt_s = ST_RAMP_UP;
               hold_nxt_s  = {HW{1'b0}};
            end else if (tick_r) begin
               hold_nxt_s = hold_r + HW'(1);
            end else begin
               hold_nxt_s = hold_r;
            end
         end
         default: begin
            state_nxt_s = ST_MANUAL;
         end
      endcase
   end

   // FSM state, linear duty and hold counter registers.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         state_r <= ST_MANUAL;
         duty_r  <= 8'd0;
         hold_r  <= {HW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         duty_r  <= duty_nxt_s;
         hold_r  <= hold_nxt_s;
      end
   end

`ifdef GAMMA_CORRECT_EN
   logic [7:0] gamma_r;

   // Perceptual square-law map, rounded up so that 1 still maps to 1.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         gamma_r <= 8'd0;
      end else begin
         gamma_r <= 8'((({8'd0, duty_r} * {8'd0, duty_r}) + 16'd255) >> 8);
      end
   end

   assign duty_o = gamma_r;
`else
   assign duty_o = duty_r;
`endif

   assign tick_o  = tick_r;
   assign state_o = state_r;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: stimulus queues expected output changes, a monitor
// pops one entry for every change it observes on the duty/state outputs.
`timescale 1ns/1ps

module tb_pwm_duty_sequencer;

   localparam int TICK_DIV = 4;
   localparam int DEB      = 2;
   localparam int HOLD     = 3;
   localparam int STEP     = 1;
`ifdef GAMMA_CORRECT_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       CLK_i = 1'b0;
   logic       RST_i = 1'b1;
   logic       BTN_UP_N_i = 1'b1;
   logic       BTN_DN_N_i = 1'b1;
   logic       MODE_i = 1'b0;
   logic [7:0] duty_o;
   logic       tick_o;
   logic [2:0] state_o;

   int          checks = 0;
   int          errors = 0;
   logic [10:0] exp_q[$];
   logic [10:0] last_push;

   pwm_duty_sequencer #(
      .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HOLD), .STEP(STEP)
   ) dut (
      .CLK_i(CLK_i), .RST_i(RST_i), .BTN_UP_N_i(BTN_UP_N_i), .BTN_DN_N_i(BTN_DN_N_i),
      .MODE_i(MODE_i), .duty_o(duty_o), .tick_o(tick_o), .state_o(state_o)
   );

   always #5 CLK_i = ~CLK_i;

   function automatic logic [7:0] exp_duty(input int d);
`ifdef GAMMA_CORRECT_EN
      return 8'(((d * d) + 255) >> 8);
`else
      return 8'(d);
`endif
   endfunction

   function automatic logic [10:0] out_key(input logic [2:0] st, input int d);
`ifdef GAMMA_CORRECT_EN
      return {3'd0, exp_duty(d)};
`else
      return {st, exp_duty(d)};
`endif
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic push(input logic [2:0] st, input int d);
      logic [10:0] k;
      k = out_key(st, d);
      if (k != last_push) begin
         exp_q.push_back(k);
         last_push = k;
      end
   endtask

   task automatic push_range(input logic [2:0] st, input int a, input int b);
      if (a <= b) begin
         for (int i = a; i <= b; i++) push(st, i);
      end else begin
         for (int i = a; i >= b; i--) push(st, i);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge CLK_i);
         n++;
      end while (!tick_o && n < 20);
      if (!tick_o) timeout("wait_tick");
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick();
   endtask

   task automatic wait_state(input logic [2:0] s, input int bound);
      int n = 0;
      while (state_o != s && n < bound) begin
         @(negedge CLK_i);
         n++;
      end
      if (state_o != s) timeout("wait_state");
   endtask

   task automatic hold_btn(input logic up, input logic dn, input int n);
      wait_tick();
      BTN_UP_N_i = ~up;
      BTN_DN_N_i = ~dn;
      wait_ticks(n);
      BTN_UP_N_i = 1'b1;
      BTN_DN_N_i = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge CLK_i);
         n++;
      end
      wait_ticks(4);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic tick_period();
      int n = 0;
      wait_tick();
      do begin
         @(negedge CLK_i);
         n++;
      end while (!tick_o && n < 20);
      check("tick_period", n, TICK_DIV);
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      logic [10:0] key_now, prev_key, req;
      logic [7:0]  prev_duty;
      logic [2:0]  prev_state;
      logic        tick_hist[2];
      int          hold_cnt;
      prev_key = '0; prev_duty = '0; prev_state = '0; hold_cnt = 0;
      tick_hist[0] = 1'b0; tick_hist[1] = 1'b0;
      forever begin
         @(posedge CLK_i);
         #1;
`ifdef GAMMA_CORRECT_EN
         key_now = {3'd0, duty_o};
`else
         key_now = {state_o, duty_o};
`endif
         if (RST_i) begin
            hold_cnt = 0;
            tick_hist[0] = 1'b0;
            tick_hist[1] = 1'b0;
         end else begin
            if (key_now != prev_key) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL scoreboard_unexpected actual=%0d required=no_change", key_now);
               end else begin
                  req = exp_q.pop_front();
                  check("scoreboard", int'(key_now), int'(req));
               end
            end
            if (duty_o != prev_duty) check("step_after_tick", int'(tick_hist[LAT-1]), 1);
            if (state_o != prev_state) begin
               if ((prev_state == 3'd2 || prev_state == 3'd4) && state_o != 3'd0)
                  check("hold_ticks", hold_cnt, HOLD);
               hold_cnt = 0;
            end
            if ((state_o == 3'd2 || state_o == 3'd4) && tick_o) hold_cnt++;
            tick_hist[1] = tick_hist[0];
            tick_hist[0] = tick_o;
         end
         prev_key = key_now;
         prev_duty = duty_o;
         prev_state = state_o;
      end
   end

   // Stimulus.
   initial begin
      int n, cyc;
      last_push = out_key(3'd0, 0);
      repeat (3) @(negedge CLK_i);
      check("reset_state", int'({duty_o, state_o, tick_o}), 0);
      RST_i = 1'b0;
      tick_period();
      tick_period();

      // MANUAL up for 20 ticks, measuring press-to-first-step in ticks.
      push_range(3'd0, 1, 20);
      wait_tick();
      BTN_UP_N_i = 1'b0;
      n = 0; cyc = 0;
      while (duty_o == 8'd0 && cyc < 100) begin
         @(negedge CLK_i);
         cyc++;
         if (tick_o) n++;
      end
      check("press_to_step_ticks", n, DEB);
      wait_ticks(20 - n);
      BTN_UP_N_i = 1'b1;
      drain("up20");

      push_range(3'd0, 19, 2);
      hold_btn(1'b0, 1'b1, 18);
      drain("down18");
      push_range(3'd0, 1, 0);
      hold_btn(1'b0, 1'b1, 5);
      drain("down_floor");
      check("floor_duty", duty_o, 0);
      hold_btn(1'b1, 1'b1, 6);
      drain("both");
      hold_btn(1'b1, 1'b0, 1);
      drain("glitch");
      check("glitch_duty", duty_o, 0);

      push_range(3'd0, 1, 255);
      hold_btn(1'b1, 1'b0, 300);
      drain("up300");
      check("sat_255", duty_o, 255);
      push_range(3'd0, 254, 250);
      hold_btn(1'b0, 1'b1, 5);
      drain("down_to_250");

      // BREATHE from 250, two passes, exit during RAMP_DOWN at 100 away from a tick.
      push(3'd1, 250); push_range(3'd1, 251, 254); push(3'd2, 255);
      push(3'd3, 255); push_range(3'd3, 254, 1); push(3'd4, 0);
      push(3'd1, 0); push_range(3'd1, 1, 254); push(3'd2, 255);
      push(3'd3, 255); push_range(3'd3, 254, 100); push(3'd0, 100);
      MODE_i = 1'b1;
      wait_state(3'd1, 20);
      hold_btn(1'b0, 1'b1, 8);
      hold_btn(1'b1, 1'b0, 8);
      wait_state(3'd4, 3000);
      wait_state(3'd3, 3000);
      wait_ticks(155);
      @(negedge CLK_i);
      MODE_i = 1'b0;
      drain("breathe_exit");
      check("exit_state", state_o, 0);
      check("exit_duty", duty_o, exp_duty(100));

      // Same exit with the synced mode change landing on a tick cycle.
      push(3'd1, 100); push_range(3'd1, 101, 254); push(3'd2, 255);
      push(3'd3, 255); push_range(3'd3, 254, 100); push(3'd0, 100);
      MODE_i = 1'b1;
      wait_state(3'd3, 3000);
      wait_ticks(155);
      repeat (2) @(negedge CLK_i);
      MODE_i = 1'b0;
      drain("tick_exit");
      check("tick_exit_state", state_o, 0);
      check("tick_exit_duty", duty_o, exp_duty(100));

      // Reset asserted mid-ramp.
      push(3'd1, 100); push_range(3'd1, 101, 102);
      MODE_i = 1'b1;
      wait_state(3'd1, 20);
      wait_ticks(2);
      repeat (2) @(negedge CLK_i);
      check("pre_reset_queue", exp_q.size(), 0);
      RST_i = 1'b1;
      MODE_i = 1'b0;
      last_push = out_key(3'd0, 0);
      #1;
      check("reset_midrun", int'({duty_o, state_o, tick_o}), 0);
      repeat (2) @(negedge CLK_i);
      RST_i = 1'b0;
      tick_period();
      tick_period();
      drain("post_reset");
      check("post_reset_state", int'({duty_o, state_o}), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
